// File: rtl/sccb_config_sequencer.sv
// sccb_config_sequencer
// Walks a registered camera-init ROM from address 0 and turns every entry
// {reg, val} into one SCCB 3-phase write (DEV_ADDR, reg, val) on SIOC/SIOD.
// Entry 16'hFFF0 inserts a fixed wait and 16'hFFFF ends the table.
module sccb_config_sequencer #(
  parameter int unsigned CLK_FREQ     = 25_000_000,
  parameter int unsigned SCCB_FREQ    = 100_000,
  parameter logic [7:0]  DEV_ADDR     = 8'h42,
  parameter int unsigned DELAY_CYCLES = 250_000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  output logic [7:0]  rom_addr_o,
  input  logic [15:0] rom_data_i,
  output logic        sioc_o,
  output logic        siod_oe_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int unsigned QTR_RAW = CLK_FREQ / (4 * SCCB_FREQ);
  localparam int unsigned QTR     = (QTR_RAW > 0) ? QTR_RAW : 1;
  localparam int unsigned GAP_CYC = 4 * QTR;
  localparam int unsigned CNT_MAX = (DELAY_CYCLES > GAP_CYC) ? DELAY_CYCLES : GAP_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] QTR_LAST   = CW'(QTR - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] DELAY_LAST = CW'(DELAY_CYCLES - 1);
  localparam logic [CW-1:0] FETCH_LAST = CW'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_XFER   = 3'd3;
  localparam logic [2:0] S_DELAY  = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;
  localparam logic [2:0] S_FINISH = 3'd6;

  // Sub-phases of one SCCB write: start condition, 27 data bits, stop condition
  localparam logic [1:0] X_START = 2'd0;
  localparam logic [1:0] X_BITS  = 2'd1;
  localparam logic [1:0] X_STOP  = 2'd2;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    xph_q, xph_d;
  logic [1:0]    qidx_q, qidx_d;
  logic [4:0]    bit_q, bit_d;
  logic [7:0]    addr_q, addr_d;
  logic [15:0]   entry_q, entry_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          sioc_q, sioc_d;
  logic          siod_oe_q, siod_oe_d;

  logic [1:0]    byte_sel;
  logic [3:0]    bit_mod;
  logic [3:0]    bit_idx;
  logic [7:0]    cur_byte;
  logic [8:0]    frame;

  // Sequencer control: walks states and advances the quarter/bit/address counters
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xph_d   = xph_q;
    qidx_d  = qidx_q;
    bit_d   = bit_q;
    addr_d  = addr_q;
    entry_d = entry_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d  = 8'd0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (cnt_q == FETCH_LAST) begin
          entry_d = rom_data_i;
          cnt_d   = '0;
          state_d = S_DECODE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DECODE: begin
        cnt_d  = '0;
        xph_d  = X_START;
        qidx_d = 2'd0;
        bit_d  = 5'd0;
        if (entry_q == 16'hFFFF) begin
          state_d = S_FINISH;
        end else if (entry_q == 16'hFFF0) begin
          state_d = S_DELAY;
        end else begin
          state_d = S_XFER;
        end
      end
      S_DELAY: begin
        if (cnt_q == DELAY_LAST) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_XFER: begin
        if (cnt_q == QTR_LAST) begin
          cnt_d = '0;
          case (xph_q)
            X_START: begin
              if (qidx_q == 2'd1) begin
                xph_d  = X_BITS;
                qidx_d = 2'd0;
                bit_d  = 5'd0;
              end else begin
                qidx_d = qidx_q + 2'd1;
              end
            end
            X_BITS: begin
              qidx_d = qidx_q + 2'd1;
              if (qidx_q == 2'd3) begin
                if (bit_q == 5'd26) begin
                  xph_d = X_STOP;
                end else begin
                  bit_d = bit_q + 5'd1;
                end
              end
            end
            default: begin
              if (qidx_q == 2'd2) begin
                qidx_d  = 2'd0;
                state_d = S_GAP;
              end else begin
                qidx_d = qidx_q + 2'd1;
              end
            end
          endcase
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          addr_d  = addr_q + 8'd1;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bit selection: bit/9 picks the byte, 8 - bit%9 the position (position 0 is the released ninth bit)
  always_comb begin
    byte_sel = 2'(bit_d / 5'd9);
    bit_mod  = 4'(bit_d % 5'd9);
    bit_idx  = 4'd8 - bit_mod;
    case (byte_sel)
      2'd0:    cur_byte = DEV_ADDR;
      2'd1:    cur_byte = entry_q[15:8];
      default: cur_byte = entry_q[7:0];
    endcase
    frame = {cur_byte, 1'b1};
  end

  // Pin levels decoded from the next state so SIOC/SIOD come straight from flops
  always_comb begin
    sioc_d    = 1'b1;
    siod_oe_d = 1'b0;
    if (state_d == S_XFER) begin
      case (xph_d)
        X_START: begin
          sioc_d    = (qidx_d == 2'd0);
          siod_oe_d = 1'b1;
        end
        X_BITS: begin
          sioc_d    = qidx_d[1];
          siod_oe_d = ~frame[bit_idx];
        end
        default: begin
          sioc_d    = (qidx_d != 2'd0);
          siod_oe_d = (qidx_d != 2'd2);
        end
      endcase
    end
  end

  // State and output registers; reset releases the bus immediately
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      xph_q     <= X_START;
      qidx_q    <= 2'd0;
      bit_q     <= 5'd0;
      addr_q    <= 8'd0;
      entry_q   <= 16'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sioc_q    <= 1'b1;
      siod_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      xph_q     <= xph_d;
      qidx_q    <= qidx_d;
      bit_q     <= bit_d;
      addr_q    <= addr_d;
      entry_q   <= entry_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sioc_q    <= sioc_d;
      siod_oe_q <= siod_oe_d;
    end
  end

  assign rom_addr_o = addr_q;
  assign sioc_o     = sioc_q;
  assign siod_oe_o  = siod_oe_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// tb_sccb_config_sequencer
// Drives the sequencer from a behavioural ROM, decodes the SCCB pins with a
// bus monitor and compares the decoded writes, final address, flags and busy
// length against a table-walking model of the init ROM.
module tb_sccb_config_sequencer;

  localparam int Q  = 2;
  localparam int DC = 100;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        sioc;
  logic        siod_oe;
  logic        busy;
  logic        done;

  sccb_config_sequencer #(
    .CLK_FREQ    (200),
    .SCCB_FREQ   (25),
    .DEV_ADDR    (8'h42),
    .DELAY_CYCLES(DC)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .rom_addr_o(rom_addr),
    .rom_data_i(rom_data),
    .sioc_o    (sioc),
    .siod_oe_o (siod_oe),
    .busy_o    (busy),
    .done_o    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered ROM: data follows the address by one clock
  logic [15:0] rom [256];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Bus monitor: decodes start/stop conditions and bits latched on SIOC rising
  logic [23:0] mon_q[$];
  int          mon_t0[$];
  int          mon_t1[$];
  int          proto_err = 0;
  int          abort_cnt = 0;
  bit          in_frame = 0;
  int          nbits = 0;
  logic [27:0] shreg = '0;
  int          t_start = 0;
  logic        prev_c = 1'b1;
  logic        prev_d = 1'b1;
  logic        now_c;
  logic        now_d;

  always @(negedge clk) begin
    now_c = sioc;
    now_d = ~siod_oe;
    if (!rst_n) begin
      in_frame = 0;
    end else if (prev_c && now_c && prev_d && !now_d) begin
      if (in_frame) abort_cnt++;
      in_frame = 1;
      nbits    = 0;
      shreg    = '0;
      t_start  = cyc;
    end else if (prev_c && now_c && !prev_d && now_d) begin
      if (!in_frame || nbits != 28 || shreg[0] != 1'b0 || shreg[1] != 1'b1 ||
          shreg[10] != 1'b1 || shreg[19] != 1'b1) begin
        proto_err++;
      end else begin
        mon_q.push_back({shreg[27:20], shreg[18:11], shreg[9:2]});
        mon_t0.push_back(t_start);
        mon_t1.push_back(cyc);
      end
      in_frame = 0;
    end else if (!prev_c && now_c) begin
      if (!in_frame) proto_err++;
      else begin
        shreg = {shreg[26:0], now_d};
        nbits++;
      end
    end else if (!in_frame && !now_c) begin
      proto_err++;
    end
    prev_c = now_c;
    prev_d = now_d;
  end

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: walk the table by its rules and tally writes and clock cost
  logic [23:0] exp_q[$];
  int exp_addr;
  int exp_cycles;

  task automatic modelRom();
    exp_q.delete();
    exp_addr   = 0;
    exp_cycles = 4;
    for (int a = 0; a < 256; a++) begin
      if (rom[a] == 16'hFFFF) begin
        exp_addr = a;
        break;
      end else if (rom[a] == 16'hFFF0) begin
        exp_cycles += 3 + DC + 4 * Q;
      end else begin
        exp_q.push_back({8'h42, rom[a]});
        exp_cycles += 3 + 27 * 4 * Q + 5 * Q + 4 * Q;
      end
    end
  endtask

  task automatic clearRom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    start = 1'b1;
  endtask

  int lastBase = 0;

  task automatic runSeq(input string name, input bit inject);
    int base;
    int perr0;
    int busy_cnt;
    int got;
    int limit;
    modelRom();
    base     = mon_q.size();
    lastBase = base;
    perr0    = proto_err;
    busy_cnt = 0;
    got      = 0;
    limit    = exp_cycles + 50;
    applyStimulus();
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      start = (inject && i == 40);
      if (busy) busy_cnt++;
      if (done) begin
        got = 1;
        break;
      end
    end
    start = 1'b0;
    checkOutput({name, "_done_seen"}, got, 1);
    checkOutput({name, "_done"}, {31'd0, done}, 1);
    checkOutput({name, "_busy"}, {31'd0, busy}, 0);
    checkOutput({name, "_addr"}, {24'd0, rom_addr}, exp_addr);
    checkOutput({name, "_nwrites"}, mon_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < mon_q.size())
        checkOutput($sformatf("%s_w%0d", name, i), {8'd0, mon_q[base + i]}, {8'd0, exp_q[i]});
    end
    total++;
    if (busy_cnt < exp_cycles - 1 || busy_cnt > exp_cycles) begin
      bad++;
      $display("[TB] FAIL %s_busylen: got %0d expected %0d..%0d", name, busy_cnt, exp_cycles - 1, exp_cycles);
    end
    checkOutput({name, "_proto"}, proto_err - perr0, 0);
  endtask

  typedef struct {
    logic [15:0] entry;
    int          exp_writes;
    logic [23:0] exp_word;
    int          exp_addr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int gap;
    int reached;
    logic [15:0] e;
    int n;
    int r;

    vecs[0] = '{16'h1280, 1, 24'h421280, 1};
    vecs[1] = '{16'hFF00, 1, 24'h42FF00, 1};
    vecs[2] = '{16'hFFFE, 1, 24'h42FFFE, 1};
    vecs[3] = '{16'hFEF0, 1, 24'h42FEF0, 1};
    vecs[4] = '{16'hFFF0, 0, 24'h000000, 1};
    vecs[5] = '{16'hFFFF, 0, 24'h000000, 0};
    vecs[6] = '{16'h0000, 1, 24'h420000, 1};
    vecs[7] = '{16'hA55A, 1, 24'h42A55A, 1};

    clearRom();
    rst_n = 1'b0;
    start = 1'b0;

    // Reset holds the bus idle and all flags low
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("rst_sioc%0d", i), {31'd0, sioc}, 1);
      checkOutput($sformatf("rst_oe%0d", i), {31'd0, siod_oe}, 0);
      checkOutput($sformatf("rst_busy%0d", i), {31'd0, busy}, 0);
      checkOutput($sformatf("rst_done%0d", i), {31'd0, done}, 0);
      checkOutput($sformatf("rst_addr%0d", i), {24'd0, rom_addr}, 0);
    end
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single-entry tables, each followed by the end marker
    for (int v = 0; v < 8; v++) begin
      clearRom();
      rom[0] = vecs[v].entry;
      runSeq($sformatf("vec%0d", v), 1'b0);
      checkOutput($sformatf("vec%0d_tcount", v), mon_q.size() - lastBase, vecs[v].exp_writes);
      if (vecs[v].exp_writes > 0 && mon_q.size() > lastBase)
        checkOutput($sformatf("vec%0d_tword", v), {8'd0, mon_q[lastBase]}, {8'd0, vecs[v].exp_word});
      checkOutput($sformatf("vec%0d_taddr", v), {24'd0, rom_addr}, vecs[v].exp_addr);
    end

    // Delay entry between two writes stretches the bus idle time
    clearRom();
    rom[0] = 16'h1280;
    rom[1] = 16'hFFF0;
    rom[2] = 16'h1204;
    runSeq("t3", 1'b0);
    total++;
    if (mon_t0.size() >= lastBase + 2) begin
      gap = mon_t0[lastBase + 1] - mon_t1[lastBase];
      if (gap < DC + 4 * Q) begin
        bad++;
        $display("[TB] FAIL t3_gap: got %0d expected >= %0d", gap, DC + 4 * Q);
      end
    end else begin
      bad++;
      $display("[TB] FAIL t3_gap: got %0d frames expected 2", mon_t0.size() - lastBase);
    end

    // Start pulse in the middle of the first byte must be ignored
    clearRom();
    rom[0] = 16'h1280;
    runSeq("t4", 1'b1);

    // Reset during the second byte aborts, then a new start begins at address 0
    clearRom();
    rom[0] = 16'h1280;
    rom[1] = 16'h1204;
    applyStimulus();
    reached = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (in_frame && nbits >= 12) begin
        reached = 1;
        break;
      end
    end
    checkOutput("t5_reach", reached, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_sioc", {31'd0, sioc}, 1);
    checkOutput("t5_oe", {31'd0, siod_oe}, 0);
    checkOutput("t5_busy", {31'd0, busy}, 0);
    checkOutput("t5_addr", {24'd0, rom_addr}, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    runSeq("t5", 1'b0);
    if (mon_q.size() > lastBase)
      checkOutput("t5_first", {8'd0, mon_q[lastBase]}, 32'h00421280);

    // Randomised tables against the model
    for (int k = 0; k < 6; k++) begin
      clearRom();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 9);
        if (r == 0) e = 16'hFFF0;
        else if (r == 1) e = {8'hFF, 8'($urandom_range(0, 239))};
        else begin
          e = 16'($urandom);
          if (e == 16'hFFFF || e == 16'hFFF0) e = 16'h1234;
        end
        rom[i] = e;
      end
      runSeq($sformatf("rnd%0d", k), 1'b0);
    end

    // Full camera init table, run twice to confirm restart repeats identically
    clearRom();
    rom[0] = 16'h1280;
    rom[1] = 16'hFFF0;
    for (int a = 2; a < 59; a++) rom[a] = {8'h10 + 8'(a), 8'(a * 37)};
    runSeq("t6a", 1'b0);
    checkOutput("t6a_final", {24'd0, rom_addr}, 59);
    runSeq("t6b", 1'b0);
    checkOutput("t6b_final", {24'd0, rom_addr}, 59);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
